axi_mem_responder: RTL and testbench

- AXI4 slave memory model that answers the kernel's AXI4 master read and write channels, using the same reduced signal subset.
- Backed by an internal word-addressed memory array.
- Read and write channels run as independent state machines.
- Used as the device-memory stand-in for kernel-level simulation. Also usable as an on-chip scratch memory behind the kernel master.

---
 rtl/axi_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: reduced-subset read/write channels
// backed by a word-addressed array, one outstanding burst per side.
module axi_mem_responder #(
   parameter int C_AXI_ADDR_WIDTH = 64,
   parameter int C_AXI_DATA_WIDTH = 512,
   parameter int C_MEM_DEPTH      = 1024
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]                    s_axi_awlen,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                          s_axi_wlast,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]                    s_axi_arlen,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic [C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic                          s_axi_rlast,
   output logic                          err_wlast,
   output logic [31:0]                   wr_burst_cnt,
   output logic [31:0]                   rd_burst_cnt
);

   localparam int NB  = C_AXI_DATA_WIDTH / 8;
   localparam int LSB = $clog2(NB);
   localparam int IW  = $clog2(C_MEM_DEPTH);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic [C_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

   w_state_t    w_state, w_state_n;
   logic [IW-1:0] w_idx, w_idx_n;
   logic [7:0]  w_cnt, w_cnt_n;
   logic        err_n;
   logic [31:0] wr_cnt_n;
   logic        mem_we;

   r_state_t    r_state, r_state_n;
   logic [IW-1:0] r_idx, r_idx_n;
   logic [7:0]  r_cnt, r_cnt_n;
   logic [31:0] rd_cnt_n;
   logic        rd_en;
   logic [IW-1:0] rd_addr;

   logic unused_addr;
   assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

   assign s_axi_awready = (w_state == W_IDLE);
   assign s_axi_wready  = (w_state == W_DATA);
   assign s_axi_bvalid  = (w_state == W_RESP);
   assign s_axi_arready = (r_state == R_IDLE);
   assign s_axi_rvalid  = (r_state == R_DATA);
   assign s_axi_rlast   = (r_state == R_DATA) && (r_cnt == 8'd0);

   always_comb begin
      w_state_n = w_state;
      w_idx_n   = w_idx;
      w_cnt_n   = w_cnt;
      err_n     = err_wlast;
      wr_cnt_n  = wr_burst_cnt;
      mem_we    = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            if (s_axi_awvalid) begin
               w_idx_n   = s_axi_awaddr[LSB +: IW];
               w_cnt_n   = s_axi_awlen;
               w_state_n = W_DATA;
            end
         end
         W_DATA: begin
            if (s_axi_wvalid) begin
               mem_we  = 1'b1;
               w_idx_n = w_idx + IW'(1);
               // Beat count alone ends the burst; wlast is only audited.
               if (s_axi_wlast != (w_cnt == 8'd0))
                  err_n = 1'b1;
               if (w_cnt == 8'd0)
                  w_state_n = W_RESP;
               else
                  w_cnt_n = w_cnt - 8'd1;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               wr_cnt_n  = wr_burst_cnt + 32'd1;
               w_state_n = W_IDLE;
            end
         end
         default: w_state_n = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state      <= W_IDLE;
         w_idx        <= '0;
         w_cnt        <= '0;
         err_wlast    <= 1'b0;
         wr_burst_cnt <= '0;
      end else begin
         w_state      <= w_state_n;
         w_idx        <= w_idx_n;
         w_cnt        <= w_cnt_n;
         err_wlast    <= err_n;
         wr_burst_cnt <= wr_cnt_n;
      end
   end

   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++)
            if (s_axi_wstrb[i])
               mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
   end

   always_comb begin
      r_state_n = r_state;
      r_idx_n   = r_idx;
      r_cnt_n   = r_cnt;
      rd_cnt_n  = rd_burst_cnt;
      rd_en     = 1'b0;
      rd_addr   = r_idx + IW'(1);
      unique case (r_state)
         R_IDLE: begin
            if (s_axi_arvalid) begin
               rd_addr   = s_axi_araddr[LSB +: IW];
               rd_en     = 1'b1;
               r_idx_n   = rd_addr;
               r_cnt_n   = s_axi_arlen;
               r_state_n = R_DATA;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               // Prefetch the next beat on the accepting edge: no bubbles.
               if (r_cnt != 8'd0) begin
                  rd_en   = 1'b1;
                  r_idx_n = rd_addr;
                  r_cnt_n = r_cnt - 8'd1;
               end else begin
                  rd_cnt_n  = rd_burst_cnt + 32'd1;
                  r_state_n = R_IDLE;
               end
            end
         end
         default: r_state_n = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state      <= R_IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         rd_burst_cnt <= '0;
         s_axi_rdata  <= '0;
      end else begin
         r_state      <= r_state_n;
         r_idx        <= r_idx_n;
         r_cnt        <= r_cnt_n;
         rd_burst_cnt <= rd_cnt_n;
         if (rd_en)
            s_axi_rdata <= mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: table-driven bursts, hand corner
// sequences and randomized concurrent traffic against a memory model.
module tb_axi_mem_responder;

   localparam int AW = 64;
   localparam int DW = 512;
   localparam int NB = DW / 8;
   localparam int DEPTH = 1024;

   typedef logic [DW-1:0] word_t;
   typedef logic [NB-1:0] strb_t;
   typedef word_t wq_t[$];
   typedef strb_t sq_t[$];

   typedef struct {
      logic [AW-1:0] addr;
      int            len;
      int            idx;
   } vec_t;

   logic          aclk = 1'b0;
   logic          areset;
   logic          awvalid, awready;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic          wvalid, wready;
   word_t         wdata;
   strb_t         wstrb;
   logic          wlast;
   logic          bvalid, bready;
   logic          arvalid, arready;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic          rvalid, rready;
   word_t         rdata;
   logic          rlast;
   logic          err_wlast;
   logic [31:0]   wr_burst_cnt, rd_burst_cnt;

   int    checks = 0;
   int    failures = 0;
   int    wr_exp = 0;
   int    rd_exp = 0;
   logic  err_exp = 1'b0;
   word_t model [DEPTH];

   always #5 aclk = ~aclk;

   axi_mem_responder dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_awaddr  (awaddr),
      .s_axi_awlen   (awlen),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wlast   (wlast),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_araddr  (araddr),
      .s_axi_arlen   (arlen),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .s_axi_rdata   (rdata),
      .s_axi_rlast   (rlast),
      .err_wlast     (err_wlast),
      .wr_burst_cnt  (wr_burst_cnt),
      .rd_burst_cnt  (rd_burst_cnt)
   );

   task automatic check(input string nm, input word_t act,
                        input word_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic word_t rnd_word();
      word_t r;
      for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   function automatic int idx_of(input logic [AW-1:0] a);
      return int'((a / 64) % DEPTH);
   endfunction

   function automatic wq_t model_q(input int idx, input int len);
      wq_t q;
      for (int b = 0; b <= len; b++) q.push_back(model[(idx + b) % DEPTH]);
      return q;
   endfunction

   task automatic write_burst(input logic [AW-1:0] addr, input int len,
                              input int idx, input wq_t d, input sq_t s,
                              input int bad, input int bdly);
      int n;
      int i;
      @(negedge aclk);
      awvalid = 1'b1;
      awaddr  = addr;
      awlen   = len[7:0];
      n = 0;
      while (!awready && n < 200) begin @(negedge aclk); n++; end
      check("aw_wait", awready, 1);
      @(posedge aclk);
      for (int b = 0; b <= len; b++) begin
         @(negedge aclk);
         awvalid = 1'b0;
         if (b > 0) check("err_wlast_beat", err_wlast, err_exp);
         wvalid = 1'b1;
         wdata  = d[b];
         wstrb  = s[b];
         wlast  = (b == len) ^ (b == bad);
         n = 0;
         while (!wready && n < 200) begin @(negedge aclk); n++; end
         check("w_wait", wready, 1);
         @(posedge aclk);
         i = (idx + b) % DEPTH;
         for (int k = 0; k < NB; k++)
            if (s[b][k]) model[i][8*k +: 8] = d[b][8*k +: 8];
         if (wlast != (b == len)) err_exp = 1'b1;
      end
      @(negedge aclk);
      wvalid = 1'b0;
      wlast  = 1'b0;
      check("err_wlast_end", err_wlast, err_exp);
      for (int k = 0; k < bdly; k++) begin
         check("bvalid_hold", bvalid, 1);
         @(negedge aclk);
      end
      bready = 1'b1;
      check("bvalid", bvalid, 1);
      @(posedge aclk);
      @(negedge aclk);
      bready = 1'b0;
      wr_exp++;
      check("bvalid_drop", bvalid, 0);
      check("wr_burst_cnt", wr_burst_cnt, wr_exp);
   endtask

   task automatic read_burst(input logic [AW-1:0] addr, input int len,
                             input int mode, input wq_t exp);
      int    n;
      int    b = 0;
      int    c = 0;
      logic  stall = 1'b0;
      word_t pd = '0;
      logic  pl = 1'b0;
      @(negedge aclk);
      arvalid = 1'b1;
      araddr  = addr;
      arlen   = len[7:0];
      n = 0;
      while (!arready && n < 200) begin @(negedge aclk); n++; end
      check("ar_wait", arready, 1);
      @(posedge aclk);
      while (b <= len && c < 2000) begin
         @(negedge aclk);
         arvalid = 1'b0;
         case (mode)
            0:       rready = 1'b1;
            1:       rready = (c % 3 == 0);
            default: rready = 1'($urandom_range(0, 1));
         endcase
         check("rvalid", rvalid, 1);
         if (stall) begin
            check("rdata_stall", rdata, pd);
            check("rlast_stall", rlast, pl);
         end
         if (rready) begin
            check("rdata", rdata, exp[b]);
            check("rlast", rlast, (b == len));
         end
         stall = !rready;
         pd = rdata;
         pl = rlast;
         @(posedge aclk);
         if (rready) b++;
         c++;
      end
      check("r_beats", b, len + 1);
      @(negedge aclk);
      rready = 1'b0;
      rd_exp++;
      check("rvalid_drop", rvalid, 0);
      check("rd_burst_cnt", rd_burst_cnt, rd_exp);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      vec_t  tbl [5];
      wq_t   d;
      wq_t   e;
      sq_t   s;
      word_t v0;
      word_t v1;
      logic [AW-1:0] a;
      int    idx;
      int    len;
      int    ridx;
      int    rlen;

      tbl[0] = '{64'h0000_0000_0000_1000, 3, 64};
      tbl[1] = '{64'h0000_0000_0000_FFC0, 1, 1023};
      tbl[2] = '{64'hDEAD_0000_0000_0145, 0, 5};
      tbl[3] = '{64'h003F_FFFF_FFFF_FFC7, 2, 1023};
      tbl[4] = '{64'h0000_0000_0000_8040, 4, 513};

      areset = 1'b1;
      {awvalid, wvalid, bready, arvalid, rready, wlast} = '0;
      awaddr = '0; awlen = '0; wdata = '0; wstrb = '0;
      araddr = '0; arlen = '0;
      repeat (3) @(negedge aclk);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", err_wlast, 0);
      check("rst_wcnt", wr_burst_cnt, 0);
      check("rst_rcnt", rd_burst_cnt, 0);
      areset = 1'b0;
      @(negedge aclk);
      check("rst_awready", awready, 1);
      check("rst_arready", arready, 1);
      check("rst_wready", wready, 0);

      for (int blk = 0; blk < 4; blk++) begin
         d.delete(); s.delete();
         for (int b = 0; b < 256; b++) begin
            d.push_back(rnd_word());
            s.push_back('1);
         end
         write_burst(AW'(blk * 256 * 64), 255, blk * 256, d, s, -1, 0);
      end

      for (int t = 0; t < 5; t++) begin
         d.delete(); s.delete();
         for (int b = 0; b <= tbl[t].len; b++) begin
            d.push_back(word_t'(t * 256 + b));
            s.push_back('1);
         end
         write_burst(tbl[t].addr, tbl[t].len, tbl[t].idx, d, s, -1, 0);
         a = (tbl[t].addr ^ (64'hA5 << 56)) | 64'h3F;
         read_burst(a, tbl[t].len, 0, d);
      end

      d.delete(); s.delete(); e.delete();
      d.push_back('1); s.push_back('1);
      write_burst(64'h140, 0, 5, d, s, -1, 0);
      d.delete(); s.delete();
      d.push_back('0); s.push_back(strb_t'(64'hF));
      write_burst(64'h140, 0, 5, d, s, -1, 0);
      e.push_back({{(DW-32){1'b1}}, 32'h0});
      read_burst(64'h140, 0, 0, e);

      d.delete(); s.delete();
      for (int b = 0; b < 8; b++) begin
         d.push_back(rnd_word());
         s.push_back('1);
      end
      write_burst(64'h4000, 7, 256, d, s, -1, 5);
      read_burst(64'h4000, 7, 1, d);

      d.delete(); s.delete();
      for (int b = 0; b < 4; b++) begin
         d.push_back(rnd_word());
         s.push_back('1);
      end
      check("err_before", err_wlast, 0);
      write_burst(64'h5000, 3, 320, d, s, 1, 0);
      check("err_set", err_wlast, 1);
      read_burst(64'h5000, 3, 2, d);

      v0 = model[7];
      v1 = rnd_word();
      d.delete(); s.delete(); e.delete();
      d.push_back(v1); s.push_back('1); e.push_back(v0);
      fork
         write_burst(64'h1C0, 0, 7, d, s, -1, 0);
         begin
            @(negedge aclk);
            read_burst(64'h1C0, 0, 0, e);
         end
      join
      e.delete();
      e.push_back(v1);
      read_burst(64'h1C0, 0, 0, e);
      check("err_sticky", err_wlast, 1);

      for (int it = 0; it < 12; it++) begin
         idx  = (it % 2) * 512 + $urandom_range(0, 500);
         len  = $urandom_range(0, 7);
         ridx = (1 - it % 2) * 512 + $urandom_range(0, 500);
         rlen = $urandom_range(0, 7);
         a = {$urandom, $urandom};
         a[15:6] = idx[9:0];
         d.delete(); s.delete();
         for (int b = 0; b <= len; b++) begin
            d.push_back(rnd_word());
            s.push_back({$urandom, $urandom});
         end
         e = model_q(ridx, rlen);
         fork
            write_burst(a, len, idx_of(a), d, s, -1,
                        $urandom_range(0, 3));
            read_burst(AW'(ridx * 64), rlen, 2, e);
         join
         read_burst(a, len, 2, model_q(idx_of(a), len));
      end

      @(negedge aclk);
      arvalid = 1'b1;
      araddr  = 64'h1000;
      arlen   = 8'd3;
      @(posedge aclk);
      @(negedge aclk);
      arvalid = 1'b0;
      rready  = 1'b1;
      repeat (2) begin
         @(posedge aclk);
         @(negedge aclk);
      end
      check("mid_rvalid", rvalid, 1);
      areset = 1'b1;
      #1;
      check("mid_rvalid_drop", rvalid, 0);
      check("mid_wcnt", wr_burst_cnt, 0);
      check("mid_rcnt", rd_burst_cnt, 0);
      check("mid_err", err_wlast, 0);
      @(negedge aclk);
      areset = 1'b0;
      rready = 1'b0;
      wr_exp = 0;
      rd_exp = 0;
      err_exp = 1'b0;
      @(negedge aclk);
      check("post_arready", arready, 1);
      check("post_awready", awready, 1);
      check("post_rvalid", rvalid, 0);
      read_burst(64'h1000, 3, 0, model_q(64, 3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
